eth_rx_frame_ctrl: RTL and testbench

Receive-frame controller that sequences the Ethernet header parser (`header_fsm`) and the payload that follows it. It gates the parser's `enable`, checks that the four header-valid pulses arrive in order and on time, and counts payload bytes against a configured length. It then inserts an inter-frame gap and reports per-frame status plus saturating good/bad frame counters. It sits between the byte-wide receive stream and downstream payload consumers.

---
 rtl/eth_pkg.sv | 34 +++
 rtl/eth_rx_frame_ctrl_sat_counter.sv | 26 ++
 rtl/eth_rx_frame_ctrl.sv | 179 +++++++++++++++++
 tb/tb_eth_rx_frame_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet receive-frame controller.
package eth_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HEADER  = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_GAP     = 2'd3
   } state_e;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_TIMEOUT = 2'd1;
   localparam logic [1:0] ERR_ORDER   = 2'd2;
   localparam logic [1:0] ERR_DV_DROP = 2'd3;

   localparam logic [1:0] STG_PREAMBLE = 2'd0;
   localparam logic [1:0] STG_DST      = 2'd1;
   localparam logic [1:0] STG_SRC      = 2'd2;
   localparam logic [1:0] STG_TYPE_LEN = 2'd3;

   localparam int CNT_W = 16;

   // Bit order matches {preamble, dst, src, type_length}.
   function automatic logic [3:0] stage_mask(input logic [1:0] stage);
      case (stage)
         STG_PREAMBLE: stage_mask = 4'b1000;
         STG_DST:      stage_mask = 4'b0100;
         STG_SRC:      stage_mask = 4'b0010;
         STG_TYPE_LEN: stage_mask = 4'b0001;
         default:      stage_mask = 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/eth_rx_frame_ctrl_sat_counter.sv
// Saturating up-counter with synchronous reset; sticks at all-ones.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_r;

   // Count up on inc until the maximum value is reached.
   always_ff @(posedge clock) begin
      if (reset) begin
         count_r <= '0;
      end else if (inc && (count_r != '1)) begin
         count_r <= count_r + WIDTH'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;

endmodule

// File: rtl/eth_rx_frame_ctrl.sv
// Receive-frame controller: gates the header parser, checks header pulse
// order/timing, forwards the payload, inserts the inter-frame gap.
module eth_rx_frame_ctrl
   import eth_pkg::*;
#(
   parameter int HDR_TIMEOUT = 16,
   parameter int IFG_CYCLES  = 12,
   parameter int LEN_W       = 11
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cfg_enable,
   input  logic [LEN_W-1:0] cfg_payload_len,
   input  logic             rx_dv,
   input  logic [7:0]       rx_data,
   input  logic             preamble_valid,
   input  logic             dst_addr_valid,
   input  logic             src_addr_valid,
   input  logic             type_length_valid,
   output logic             parser_enable,
   output logic [7:0]       payload_data,
   output logic             payload_valid,
   output logic             payload_last,
   output logic             frame_done,
   output logic             frame_error,
   output logic [1:0]       err_code,
   output logic             busy,
   output logic [CNT_W-1:0] frame_ok_count,
   output logic [CNT_W-1:0] frame_err_count
);

   localparam int TMO_W = $clog2(HDR_TIMEOUT + 1);
   localparam int GAP_W = $clog2(IFG_CYCLES + 1);

   state_e           state_r;
   logic [1:0]       stage_r;
   logic [TMO_W-1:0] tmo_r;
   logic [GAP_W-1:0] gap_r;
   logic [LEN_W-1:0] len_r;
   logic [LEN_W-1:0] cnt_r;

   logic [3:0]       pulses_s;
   logic [3:0]       mask_s;
   logic             exp_hit_s;
   logic             other_hit_s;
   logic [LEN_W-1:0] cnt_inc_s;

   // Header pulse classification and the parser enable gate.
   always_comb begin
      pulses_s    = {preamble_valid, dst_addr_valid, src_addr_valid, type_length_valid};
      mask_s      = stage_mask(stage_r);
      exp_hit_s   = |(pulses_s & mask_s);
      other_hit_s = |(pulses_s & ~mask_s);
      cnt_inc_s   = cnt_r + LEN_W'(1);
      if (reset) begin
         parser_enable = 1'b0;
      end else if (state_r == ST_HEADER) begin
         parser_enable = 1'b1;
      end else if ((state_r == ST_IDLE) && cfg_enable && rx_dv) begin
         parser_enable = 1'b1;
      end else begin
         parser_enable = 1'b0;
      end
   end

   // Frame sequencing FSM with registered payload and status outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r       <= ST_IDLE;
         stage_r       <= STG_PREAMBLE;
         tmo_r         <= '0;
         gap_r         <= '0;
         len_r         <= '0;
         cnt_r         <= '0;
         payload_data  <= 8'h00;
         payload_valid <= 1'b0;
         payload_last  <= 1'b0;
         frame_done    <= 1'b0;
         frame_error   <= 1'b0;
         err_code      <= ERR_NONE;
      end else begin
         payload_data  <= 8'h00;
         payload_valid <= 1'b0;
         payload_last  <= 1'b0;
         frame_done    <= 1'b0;
         frame_error   <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (cfg_enable && rx_dv) begin
                  state_r <= ST_HEADER;
                  len_r   <= cfg_payload_len;
                  stage_r <= STG_PREAMBLE;
                  tmo_r   <= '0;
               end
            end
            ST_HEADER: begin
               if (other_hit_s) begin
                  frame_error <= 1'b1;
                  err_code    <= ERR_ORDER;
                  state_r     <= ST_GAP;
               end else if (exp_hit_s) begin
                  tmo_r <= '0;
                  if (stage_r != STG_TYPE_LEN) begin
                     stage_r <= stage_r + 2'd1;
                  end else if (len_r == '0) begin
                     frame_done <= 1'b1;
                     err_code   <= ERR_NONE;
                     state_r    <= ST_GAP;
                  end else begin
                     // The byte alongside type_length_valid is payload byte 0.
                     payload_valid <= rx_dv;
                     payload_data  <= rx_dv ? rx_data : 8'h00;
                     if (rx_dv && (len_r == LEN_W'(1))) begin
                        payload_last <= 1'b1;
                        frame_done   <= 1'b1;
                        err_code     <= ERR_NONE;
                        state_r      <= ST_GAP;
                     end else begin
                        cnt_r   <= rx_dv ? LEN_W'(1) : LEN_W'(0);
                        state_r <= ST_PAYLOAD;
                     end
                  end
               end else if (tmo_r == TMO_W'(HDR_TIMEOUT - 1)) begin
                  frame_error <= 1'b1;
                  err_code    <= ERR_TIMEOUT;
                  state_r     <= ST_GAP;
               end else begin
                  tmo_r <= tmo_r + TMO_W'(1);
               end
            end
            ST_PAYLOAD: begin
               if (rx_dv) begin
                  payload_valid <= 1'b1;
                  payload_data  <= rx_data;
                  cnt_r         <= cnt_inc_s;
                  if (cnt_inc_s == len_r) begin
                     payload_last <= 1'b1;
                     frame_done   <= 1'b1;
                     err_code     <= ERR_NONE;
                     state_r      <= ST_GAP;
                  end
               end else begin
                  frame_error <= 1'b1;
                  err_code    <= ERR_DV_DROP;
                  state_r     <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (gap_r == GAP_W'(IFG_CYCLES - 1)) begin
                  gap_r   <= '0;
                  state_r <= ST_IDLE;
               end else begin
                  gap_r <= gap_r + GAP_W'(1);
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy = (state_r != ST_IDLE);

   sat_counter #(.WIDTH(CNT_W)) u_ok_count (
      .clock (clock),
      .reset (reset),
      .inc   (frame_done),
      .count (frame_ok_count)
   );

   sat_counter #(.WIDTH(CNT_W)) u_err_count (
      .clock (clock),
      .reset (reset),
      .inc   (frame_error),
      .count (frame_err_count)
   );

endmodule

// File: tb/tb_eth_rx_frame_ctrl.sv
// Directed bench for eth_rx_frame_ctrl with a payload scoreboard queue.
module tb_eth_rx_frame_ctrl;

   localparam int LEN_W = 11;

   logic             clock = 1'b0;
   logic             reset;
   logic             cfg_enable;
   logic [LEN_W-1:0] cfg_payload_len;
   logic             rx_dv;
   logic [7:0]       rx_data;
   logic             preamble_valid, dst_addr_valid, src_addr_valid, type_length_valid;
   logic             parser_enable;
   logic [7:0]       payload_data;
   logic             payload_valid, payload_last, frame_done, frame_error, busy;
   logic [1:0]       err_code;
   logic [15:0]      frame_ok_count, frame_err_count;

   int checks = 0;
   int passes = 0;
   int pcyc = 0;
   int pv_cnt = 0, last_cnt = 0, done_cnt = 0, err_ev = 0;
   int done_cyc = 0, err_cyc = 0, pre_cyc = 0, tl_cyc = 0;
   logic [1:0] err_seen = 2'd0;
   logic [8:0] sb_q[$];

   eth_rx_frame_ctrl #(.HDR_TIMEOUT(16), .IFG_CYCLES(12), .LEN_W(LEN_W)) dut (
      .clock             (clock),
      .reset             (reset),
      .cfg_enable        (cfg_enable),
      .cfg_payload_len   (cfg_payload_len),
      .rx_dv             (rx_dv),
      .rx_data           (rx_data),
      .preamble_valid    (preamble_valid),
      .dst_addr_valid    (dst_addr_valid),
      .src_addr_valid    (src_addr_valid),
      .type_length_valid (type_length_valid),
      .parser_enable     (parser_enable),
      .payload_data      (payload_data),
      .payload_valid     (payload_valid),
      .payload_last      (payload_last),
      .frame_done        (frame_done),
      .frame_error       (frame_error),
      .err_code          (err_code),
      .busy              (busy),
      .frame_ok_count    (frame_ok_count),
      .frame_err_count   (frame_err_count)
   );

   always #5 clock = ~clock;

   always @(posedge clock) pcyc <= pcyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Scoreboard monitor: pops one expected byte per payload_valid cycle.
   always @(negedge clock) begin
      logic [8:0] e;
      if (payload_valid === 1'b1) begin
         pv_cnt++;
         check("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("pay_data", 32'(payload_data), 32'(e[8:1]));
            check("pay_last", 32'(payload_last), 32'(e[0]));
            check("done_with_last", 32'(frame_done), 32'(e[0]));
         end
      end
      if (payload_last === 1'b1) last_cnt++;
      if (frame_done === 1'b1) begin
         done_cnt++;
         done_cyc = pcyc;
      end
      if (frame_error === 1'b1) begin
         err_ev++;
         err_seen = err_code;
         err_cyc  = pcyc;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic drive(input logic dv, input logic [7:0] d, input logic [3:0] p);
      rx_dv = dv;
      rx_data = d;
      {preamble_valid, dst_addr_valid, src_addr_valid, type_length_valid} = p;
      @(negedge clock);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 4'b0000);
   endtask

   task automatic clr_ev();
      pv_cnt = 0; last_cnt = 0; done_cnt = 0; err_ev = 0; err_seen = 2'd0;
   endtask

   // Parser pulses arrive one cycle after the last byte of their field.
   task automatic send_header(input bit bad_dst);
      for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 4'b0000);
      drive(1'b1, 8'hD5, 4'b0000);
      for (int i = 1; i <= 6; i++) begin
         drive(1'b1, (bad_dst && i == 3) ? 8'h07 : 8'(i), (i == 1) ? 4'b1000 : 4'b0000);
         if (i == 1) pre_cyc = pcyc;
      end
      for (int i = 0; i < 6; i++)
         drive(1'b1, 8'hFF - 8'(i), (i == 0 && !bad_dst) ? 4'b0100 : 4'b0000);
      drive(1'b1, 8'h08, bad_dst ? 4'b0000 : 4'b0010);
      drive(1'b1, 8'h00, 4'b0000);
   endtask

   task automatic send_payload(input int n, input int len);
      logic [7:0] b;
      for (int k = 0; k < n; k++) begin
         b = 8'hAA + 8'(17 * k);
         if (k < len) sb_q.push_back({b, (k == len - 1)});
         drive(1'b1, b, (k == 0) ? 4'b0001 : 4'b0000);
         if (k == 0) tl_cyc = pcyc;
      end
   endtask

   initial begin
      int n;
      reset = 1'b1;
      cfg_enable = 1'b1;
      cfg_payload_len = 11'd4;
      rx_dv = 1'b1;
      rx_data = 8'h55;
      {preamble_valid, dst_addr_valid, src_addr_valid, type_length_valid} = 4'b0000;
      repeat (3) @(negedge clock);
      check("rst_parser_enable", 32'(parser_enable), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_payload_valid", 32'(payload_valid), 32'd0);
      check("rst_err_code", 32'(err_code), 32'd0);
      check("rst_ok_count", 32'(frame_ok_count), 32'd0);
      check("rst_err_count", 32'(frame_err_count), 32'd0);
      reset = 1'b0;
      idle(2);

      // Valid frame, 4 payload bytes
      clr_ev();
      send_header(1'b0);
      send_payload(4, 4);
      n = 0;
      while (busy && n < 40) begin
         n++;
         drive(1'b0, 8'h00, 4'b0000);
      end
      check("valid_busy_gap", 32'(n), 32'd12);
      idle(2);
      check("valid_pv_cnt", 32'(pv_cnt), 32'd4);
      check("valid_last_cnt", 32'(last_cnt), 32'd1);
      check("valid_done_cnt", 32'(done_cnt), 32'd1);
      check("valid_ok_count", 32'(frame_ok_count), 32'd1);
      check("valid_err_code", 32'(err_code), 32'd0);

      // Bad dst byte: no dst pulse, header times out
      clr_ev();
      send_header(1'b1);
      idle(40);
      check("tmo_err_ev", 32'(err_ev), 32'd1);
      check("tmo_err_code", 32'(err_seen), 32'd1);
      check("tmo_latency", 32'(err_cyc - pre_cyc), 32'd16);
      check("tmo_pv_cnt", 32'(pv_cnt), 32'd0);
      check("tmo_err_count", 32'(frame_err_count), 32'd1);

      // Zero payload length
      clr_ev();
      cfg_payload_len = 11'd0;
      send_header(1'b0);
      send_payload(4, 0);
      idle(16);
      check("zero_done_cnt", 32'(done_cnt), 32'd1);
      check("zero_done_lat", 32'(done_cyc), 32'(tl_cyc));
      check("zero_pv_cnt", 32'(pv_cnt), 32'd0);
      check("zero_ok_count", 32'(frame_ok_count), 32'd2);

      // rx_dv dropped after 2 of 4 payload bytes
      clr_ev();
      cfg_payload_len = 11'd4;
      send_header(1'b0);
      send_payload(2, 4);
      idle(16);
      check("drop_pv_cnt", 32'(pv_cnt), 32'd2);
      check("drop_last_cnt", 32'(last_cnt), 32'd0);
      check("drop_err_ev", 32'(err_ev), 32'd1);
      check("drop_err_code", 32'(err_seen), 32'd3);
      check("drop_err_hold", 32'(err_code), 32'd3);
      check("drop_err_count", 32'(frame_err_count), 32'd2);

      // Reset mid-payload, then a frame with a mid-frame length change
      clr_ev();
      send_header(1'b0);
      send_payload(2, 4);
      reset = 1'b1;
      drive(1'b1, 8'hCC, 4'b0000);
      check("mid_rst_pv", 32'(payload_valid), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_err", 32'(frame_error), 32'd0);
      check("mid_rst_code", 32'(err_code), 32'd0);
      check("mid_rst_ok", 32'(frame_ok_count), 32'd0);
      check("mid_rst_errcnt", 32'(frame_err_count), 32'd0);
      reset = 1'b0;
      idle(2);
      clr_ev();
      send_header(1'b0);
      cfg_payload_len = 11'd9;
      send_payload(4, 4);
      idle(16);
      check("post_rst_done", 32'(done_cnt), 32'd1);
      check("post_rst_ok", 32'(frame_ok_count), 32'd1);
      check("post_rst_err", 32'(err_ev), 32'd0);

      // Saturation of the good-frame counter
      cfg_payload_len = 11'd4;
      force dut.u_ok_count.count_r = 16'hFFFE;
      @(negedge clock);
      release dut.u_ok_count.count_r;
      for (int f = 0; f < 3; f++) begin
         send_header(1'b0);
         send_payload(4, 4);
         idle(16);
         check("sat_ok_count", 32'(frame_ok_count), 32'hFFFF);
      end

      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
